fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined MIPS processor. It owns the PC, issues instruction-memory reads, and drives the IF/ID pipeline register consumed by the decode stage. It loads the externally supplied start address on reset, honours stall requests from the hazard unit and redirects from the branch/jump logic, and keeps a one-entry skid buffer so an instruction already returned by memory during a stall is never re-read.

---
 rtl/pipe_defs.sv | 17 +
 rtl/fetch_skid.sv | 28 ++
 rtl/fetch_stage.sv | 119 +++++++++++
 tb/tb_fetch_stage.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_defs.sv
// Shared pipeline definitions for the fetch and decode stages:
// default bus widths, NOP encoding, PC increment and fetch FSM states.
package pipe_defs;

  localparam int ADDR_W_DEF  = 32;
  localparam int INSTR_W_DEF = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int          PC_INC    = 4;

  typedef enum logic [1:0] {
    RST   = 2'd0,
    FETCH = 2'd1,
    SKID  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid.sv
// One-entry holding register for an instruction returned while the pipe is stalled.
// Capture/drain take effect at the next edge; clear (or reset) wins over both.
module fetch_skid #(
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               capture,
  input  logic               drain,
  input  logic               clear,
  input  logic [INSTR_W-1:0] data,
  output logic [INSTR_W-1:0] held_data,
  output logic               held_valid
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      held_valid <= 1'b0;
      held_data  <= '0;
    end else if (capture) begin
      held_valid <= 1'b1;
      held_data  <= data;
    end else if (drain) begin
      held_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, reads instruction memory, fills IF/ID; one instr/cycle.
// Stall holds PC and IF/ID, parking a returned word in the skid; redirect flushes one slot.
module fetch_stage
  import pipe_defs::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [ADDR_W-1:0]  startPC,
  output logic [ADDR_W-1:0]  iMemAddr,
  output logic               iMemReq,
  input  logic               iMemReady,
  input  logic [INSTR_W-1:0] iMemData,
  input  logic               Stall,
  input  logic               Redirect,
  input  logic [ADDR_W-1:0]  RedirectPC,
  output logic [INSTR_W-1:0] ifidInstr,
  output logic [ADDR_W-1:0]  ifidPCPlus4,
  output logic               ifidValid,
  output logic [31:0]        fetchCount
);

  localparam logic [ADDR_W-1:0]  WORD_MASK = ~ADDR_W'(3);
  localparam logic [INSTR_W-1:0] NOP       = INSTR_W'(NOP_INSTR);

  fetch_state_t       state;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  pc_plus4;

  logic               skid_capture;
  logic               skid_drain;
  logic               skid_clear;
  logic [INSTR_W-1:0] skid_data;
  logic               skid_valid;

  assign pc_plus4 = pc + ADDR_W'(PC_INC);
  assign iMemAddr = pc;
  assign iMemReq  = (state == FETCH);

  // Redirect outranks stall and ready, so it also outranks skid capture/drain.
  assign skid_clear   = Reset || (Redirect && state != RST);
  assign skid_capture = (state == FETCH) && iMemReady && Stall && !Redirect;
  assign skid_drain   = (state == SKID) && !Stall && !Redirect;

  fetch_skid #(
    .INSTR_W(INSTR_W)
  ) u_skid (
    .clk       (CLK),
    .reset     (Reset),
    .capture   (skid_capture),
    .drain     (skid_drain),
    .clear     (skid_clear),
    .data      (iMemData),
    .held_data (skid_data),
    .held_valid(skid_valid)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      pc          <= startPC & WORD_MASK;
      state       <= RST;
      ifidInstr   <= NOP;
      ifidPCPlus4 <= '0;
      ifidValid   <= 1'b0;
      fetchCount  <= '0;
    end else begin
      case (state)
        RST: begin
          state <= FETCH;
        end

        FETCH: begin
          if (Redirect) begin
            pc          <= RedirectPC & WORD_MASK;
            ifidInstr   <= NOP;
            ifidPCPlus4 <= '0;
            ifidValid   <= 1'b0;
          end else if (iMemReady && !Stall) begin
            ifidInstr   <= iMemData;
            ifidPCPlus4 <= pc_plus4;
            ifidValid   <= 1'b1;
            pc          <= pc_plus4;
            fetchCount  <= fetchCount + 32'd1;
          end else if (iMemReady) begin
            state <= SKID;
          end else if (!Stall) begin
            ifidInstr   <= NOP;
            ifidPCPlus4 <= '0;
            ifidValid   <= 1'b0;
          end
        end

        SKID: begin
          if (Redirect) begin
            pc          <= RedirectPC & WORD_MASK;
            ifidInstr   <= NOP;
            ifidPCPlus4 <= '0;
            ifidValid   <= 1'b0;
            state       <= FETCH;
          end else if (!Stall) begin
            ifidInstr   <= skid_data;
            ifidPCPlus4 <= pc_plus4;
            ifidValid   <= skid_valid;
            pc          <= pc_plus4;
            fetchCount  <= fetchCount + 32'd1;
            state       <= FETCH;
          end
        end

        default: begin
          state <= RST;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset release, streaming, stall/skid, wait states,
// redirect with a full skid, PC wrap and reset during SKID.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [31:0] startPC;
  logic [31:0] iMemAddr;
  logic        iMemReq;
  logic        iMemReady;
  logic [31:0] iMemData;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic [31:0] ifidInstr;
  logic [31:0] ifidPCPlus4;
  logic        ifidValid;
  logic [31:0] fetchCount;

  logic        corrupt = 1'b0;
  int          total = 0;
  int          bad = 0;
  int          req_a0 = 0;

  always #5 CLK = ~CLK;

  // Combinational-read memory: each word is its address scrambled by a fixed pattern.
  assign iMemData = iMemAddr ^ 32'h1234_5678 ^ {32{corrupt}};

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'h1234_5678;
  endfunction

  fetch_stage dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .startPC    (startPC),
    .iMemAddr   (iMemAddr),
    .iMemReq    (iMemReq),
    .iMemReady  (iMemReady),
    .iMemData   (iMemData),
    .Stall      (Stall),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .ifidInstr  (ifidInstr),
    .ifidPCPlus4(ifidPCPlus4),
    .ifidValid  (ifidValid),
    .fetchCount (fetchCount)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] instr, input logic [31:0] pc4,
                          input logic vld);
    chk({tag, "_instr"}, ifidInstr, instr);
    chk({tag, "_pc4"}, ifidPCPlus4, pc4);
    chk({tag, "_vld"}, {31'd0, ifidValid}, {31'd0, vld});
  endtask

  initial begin
    Reset      = 1'b1;
    startPC    = 32'h60;
    iMemReady  = 1'b1;
    Stall      = 1'b0;
    Redirect   = 1'b0;
    RedirectPC = 32'h0;

    // Reset state
    step();
    step();
    chk_ifid("rst", 32'h0, 32'h0, 1'b0);
    chk("rst_cnt", fetchCount, 32'd0);
    chk("rst_req", {31'd0, iMemReq}, 32'd0);
    chk("rst_addr", iMemAddr, 32'h60);

    // Release: RST cycle, then request, then delivery
    Reset = 1'b0;
    chk("rel_req0", {31'd0, iMemReq}, 32'd0);
    step();
    chk("rel_req1", {31'd0, iMemReq}, 32'd1);
    chk("rel_addr1", iMemAddr, 32'h60);
    chk("rel_vld1", {31'd0, ifidValid}, 32'd0);
    step();
    chk_ifid("first", word_at(32'h60), 32'h64, 1'b1);
    for (int k = 1; k < 10; k++) begin
      step();
      chk("stream_pc4", ifidPCPlus4, 32'h64 + 32'(4 * k));
    end
    chk("stream_cnt", fetchCount, 32'd10);
    chk("stream_addr", iMemAddr, 32'h88);

    // Stall for 3 cycles at A0 with memory ready; prime IF/ID with the word at 9C
    Redirect = 1'b1; RedirectPC = 32'h9C;
    step();
    Redirect = 1'b0;
    chk_ifid("redir9c", 32'h0, 32'h0, 1'b0);
    chk("redir9c_cnt", fetchCount, 32'd10);
    step();
    chk_ifid("pre_stall", word_at(32'h9C), 32'hA0, 1'b1);
    Stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (iMemReq && iMemAddr == 32'hA0) req_a0++;
      step();
      corrupt = 1'b1;
      chk_ifid("stall_hold", word_at(32'h9C), 32'hA0, 1'b1);
      chk("stall_req", {31'd0, iMemReq}, 32'd0);
    end
    Stall = 1'b0;
    if (iMemReq && iMemAddr == 32'hA0) req_a0++;
    step();
    corrupt = 1'b0;
    chk_ifid("unstall", word_at(32'hA0), 32'hA4, 1'b1);
    chk("unstall_addr", iMemAddr, 32'hA4);
    chk("unstall_req", {31'd0, iMemReq}, 32'd1);
    chk("a0_reads", 32'(req_a0), 32'd1);
    chk("unstall_cnt", fetchCount, 32'd12);

    // Two wait states at PC 0
    Redirect = 1'b1; RedirectPC = 32'h0;
    step();
    Redirect = 1'b0;
    iMemReady = 1'b0;
    step();
    chk_ifid("wait1", 32'h0, 32'h0, 1'b0);
    chk("wait1_addr", iMemAddr, 32'h0);
    step();
    chk_ifid("wait2", 32'h0, 32'h0, 1'b0);
    chk("wait2_addr", iMemAddr, 32'h0);
    iMemReady = 1'b1;
    step();
    chk_ifid("wait_done", word_at(32'h0), 32'h4, 1'b1);
    chk("wait_cnt", fetchCount, 32'd13);

    // Redirect to 13 while stalled with the skid holding the word at 4
    Stall = 1'b1;
    step();
    chk_ifid("skid_fill", word_at(32'h0), 32'h4, 1'b1);
    Redirect = 1'b1; RedirectPC = 32'h13;
    step();
    chk_ifid("redir_skid", 32'h0, 32'h0, 1'b0);
    chk("redir_skid_addr", iMemAddr, 32'h10);
    chk("redir_skid_req", {31'd0, iMemReq}, 32'd1);
    chk("redir_skid_cnt", fetchCount, 32'd13);
    Redirect = 1'b0;
    Stall = 1'b0;
    step();
    chk_ifid("after_redir", word_at(32'h10), 32'h14, 1'b1);
    chk("after_redir_cnt", fetchCount, 32'd14);

    // PC wrap at the top of the address space
    Redirect = 1'b1; RedirectPC = 32'hFFFF_FFFC;
    step();
    Redirect = 1'b0;
    chk("wrap_addr0", iMemAddr, 32'hFFFF_FFFC);
    step();
    chk_ifid("wrap", word_at(32'hFFFF_FFFC), 32'h0, 1'b1);
    chk("wrap_addr", iMemAddr, 32'h0);
    chk("wrap_cnt", fetchCount, 32'd15);

    // Reset asserted while in SKID
    Stall = 1'b1;
    step();
    Reset = 1'b1; startPC = 32'h0;
    step();
    chk_ifid("rst_skid", 32'h0, 32'h0, 1'b0);
    chk("rst_skid_cnt", fetchCount, 32'd0);
    chk("rst_skid_req", {31'd0, iMemReq}, 32'd0);
    chk("rst_skid_addr", iMemAddr, 32'h0);
    Reset = 1'b0;
    Stall = 1'b0;
    chk("rst_skid_rel0", {31'd0, iMemReq}, 32'd0);
    step();
    chk("rst_skid_rel1", {31'd0, iMemReq}, 32'd1);
    chk("rst_skid_rel1_vld", {31'd0, ifidValid}, 32'd0);
    step();
    chk_ifid("rst_skid_first", word_at(32'h0), 32'h4, 1'b1);
    chk("rst_skid_first_cnt", fetchCount, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
